// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode map, instruction-length decode and stack-operation
//                encoding shared by the JVM integer-subset execution core.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_M1 = 8'h02;
    localparam logic [7:0] OP_ICONST_5  = 8'h08;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_SIPUSH    = 8'h11;
    localparam logic [7:0] OP_ILOAD     = 8'h15;
    localparam logic [7:0] OP_ILOAD_0   = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3   = 8'h1D;
    localparam logic [7:0] OP_ISTORE    = 8'h36;
    localparam logic [7:0] OP_ISTORE_0  = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3  = 8'h3E;
    localparam logic [7:0] OP_POP       = 8'h57;
    localparam logic [7:0] OP_DUP       = 8'h59;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_ISUB      = 8'h64;
    localparam logic [7:0] OP_IINC      = 8'h84;
    localparam logic [7:0] OP_IFEQ      = 8'h99;
    localparam logic [7:0] OP_IFNE      = 8'h9A;
    localparam logic [7:0] OP_GOTO      = 8'hA7;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        PUSH      = 3'd1,
        POP       = 3'd2,
        POP2_PUSH = 3'd3,
        DUP       = 3'd4
    } stack_op_e;

    function automatic logic [1:0] insn_len(input logic [7:0] op);
        case (op)
            OP_BIPUSH, OP_ILOAD, OP_ISTORE:                 insn_len = 2'd2;
            OP_SIPUSH, OP_IINC, OP_IFEQ, OP_IFNE, OP_GOTO: insn_len = 2'd3;
            default:                                        insn_len = 2'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_operand_stack
//  Description : Saturating LIFO operand stack; pushes when full are dropped,
//                pops when empty read zero and leave the pointer at zero.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_operand_stack
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  stack_op_e         op_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] tos_o,
    output logic [DATA_W-1:0] nos_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [SP_W-1:0]   sp_q, sp_d, base;
    logic              we;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_q [STACK_DEPTH];

    assign empty_o = (sp_q == '0);
    assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
    assign tos_o   = empty_o ? '0 : mem_q[IDX_W'(sp_q - SP_W'(1))];
    assign nos_o   = (sp_q >= SP_W'(2)) ? mem_q[IDX_W'(sp_q - SP_W'(2))] : '0;

    always_comb begin
        sp_d  = sp_q;
        we    = 1'b0;
        widx  = '0;
        wdata = (op_i == DUP) ? tos_o : data_i;
        base  = '0;
        case (op_i)
            PUSH, DUP: begin
                if (!full_o) begin
                    we   = 1'b1;
                    widx = IDX_W'(sp_q);
                    sp_d = sp_q + SP_W'(1);
                end
            end
            POP: begin
                if (!empty_o) sp_d = sp_q - SP_W'(1);
            end
            POP2_PUSH: begin
                // Missing operands read as zero, so the result lands at max(sp-2,0).
                base = (sp_q >= SP_W'(2)) ? sp_q - SP_W'(2) : '0;
                we   = 1'b1;
                widx = IDX_W'(base);
                sp_d = base + SP_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_core
//  Description : Single-cycle JVM integer-subset execution core with local
//                variable file and PC; define CPU_TRACE_EN for a per-
//                instruction simulation trace.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 16,
    parameter int NUM_LOCALS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        op_code,
    input  logic [7:0]        arg1,
    input  logic [7:0]        arg2,
    output logic [DATA_W-1:0] dataparams,
    output logic [7:0]        dataindex,
    output logic [15:0]       program_counter
);

    localparam int LIDX_W = $clog2(NUM_LOCALS);

    logic [15:0]       pc_q, pc_d;
    logic [7:0]        didx_q, didx_d;
    logic [DATA_W-1:0] locals_q [NUM_LOCALS];

    stack_op_e         stk_op;
    logic [DATA_W-1:0] stk_data, tos, nos, pop_val;
    logic              full, empty;

    logic              loc_we;
    logic [LIDX_W-1:0] loc_widx, lidx_arg;
    logic [DATA_W-1:0] loc_wdata;
    logic [DATA_W-1:0] sext_a1, sext_a2, sext_a12, iconst_val;
    logic signed [8:0] iconst;

    assign lidx_arg   = LIDX_W'(32'(arg1) % NUM_LOCALS);
    assign sext_a1    = {{(DATA_W-8){arg1[7]}}, arg1};
    assign sext_a2    = {{(DATA_W-8){arg2[7]}}, arg2};
    assign sext_a12   = {{(DATA_W-16){arg1[7]}}, arg1, arg2};
    assign iconst     = $signed({1'b0, op_code}) - 9'sd3;
    assign iconst_val = {{(DATA_W-9){iconst[8]}}, iconst};
    assign pop_val    = empty ? '0 : tos;

    always_comb begin
        pc_d      = pc_q + 16'(insn_len(op_code));
        didx_d    = didx_q;
        stk_op    = NONE;
        stk_data  = '0;
        loc_we    = 1'b0;
        loc_widx  = lidx_arg;
        loc_wdata = pop_val;
        case (op_code) inside
            [OP_ICONST_M1:OP_ICONST_5]: begin stk_op = PUSH; stk_data = iconst_val; end
            OP_BIPUSH:                  begin stk_op = PUSH; stk_data = sext_a1;    end
            OP_SIPUSH:                  begin stk_op = PUSH; stk_data = sext_a12;   end
            OP_ILOAD: begin
                stk_op   = PUSH;
                stk_data = locals_q[lidx_arg];
                didx_d   = 8'(lidx_arg);
            end
            [OP_ILOAD_0:OP_ILOAD_3]: begin
                stk_op   = PUSH;
                stk_data = locals_q[LIDX_W'(op_code - OP_ILOAD_0)];
                didx_d   = op_code - OP_ILOAD_0;
            end
            OP_ISTORE: begin
                stk_op = POP;
                loc_we = 1'b1;
                didx_d = 8'(lidx_arg);
            end
            [OP_ISTORE_0:OP_ISTORE_3]: begin
                stk_op   = POP;
                loc_we   = 1'b1;
                loc_widx = LIDX_W'(op_code - OP_ISTORE_0);
                didx_d   = op_code - OP_ISTORE_0;
            end
            OP_POP:  stk_op = POP;
            OP_DUP:  stk_op = full ? NONE : DUP;
            OP_IADD: begin stk_op = POP2_PUSH; stk_data = nos + tos; end
            OP_ISUB: begin stk_op = POP2_PUSH; stk_data = nos - tos; end
            OP_IINC: begin
                // Read and write of the same slot resolve within this cycle.
                loc_we    = 1'b1;
                loc_wdata = locals_q[lidx_arg] + sext_a2;
                didx_d    = 8'(lidx_arg);
            end
            OP_IFEQ: begin
                stk_op = POP;
                if (pop_val == '0) pc_d = pc_q + {arg1, arg2};
            end
            OP_IFNE: begin
                stk_op = POP;
                if (pop_val != '0) pc_d = pc_q + {arg1, arg2};
            end
            OP_GOTO: pc_d = pc_q + {arg1, arg2};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            didx_q <= '0;
            for (int i = 0; i < NUM_LOCALS; i++) locals_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            didx_q <= didx_d;
            if (loc_we) locals_q[loc_widx] <= loc_wdata;
        end
    end

    cpu_operand_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (stk_op),
        .data_i  (stk_data),
        .tos_o   (tos),
        .nos_o   (nos),
        .full_o  (full),
        .empty_o (empty)
    );

    assign program_counter = pc_q;
    assign dataparams      = tos;
    assign dataindex       = didx_q;

`ifdef CPU_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) $display("pc=%h op=%h tos=%h sp=%0d", pc_q, op_code, tos, u_stack.sp_q);
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_core
//  Description : Self-checking bench for cpu_core: vector table, program
//                sequences from a byte memory, and random instruction streams
//                compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  op_code = '0, arg1 = '0, arg2 = '0;
    logic [31:0] dataparams;
    logic [7:0]  dataindex;
    logic [15:0] program_counter;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_stk [$];
    logic [31:0] m_loc [16];
    logic [7:0]  m_idx;
    logic [15:0] m_pc;
    logic [7:0]  mem [256];

    typedef struct packed {
        logic [7:0]  op, a1, a2;
        logic [15:0] pc;
        logic [31:0] tos;
        logic [7:0]  idx;
    } vec_t;
    vec_t tbl [25];

    logic [7:0] valid_ops [19] = '{8'h00, 8'h02, 8'h05, 8'h08, 8'h10, 8'h11, 8'h15, 8'h1A, 8'h1D,
                                   8'h36, 8'h3B, 8'h3E, 8'h57, 8'h59, 8'h60, 8'h64, 8'h84, 8'h99, 8'h9A};

    always #5 clk = ~clk;

    cpu_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_code         (op_code),
        .arg1            (arg1),
        .arg2            (arg2),
        .dataparams      (dataparams),
        .dataindex       (dataindex),
        .program_counter (program_counter)
    );

    function automatic void m_push(input logic [31:0] v);
        if (m_stk.size() < 16) m_stk.push_back(v);
    endfunction

    function automatic logic [31:0] m_pop();
        if (m_stk.size() == 0) return 32'h0;
        return m_stk.pop_back();
    endfunction

    function automatic logic [31:0] m_top();
        if (m_stk.size() == 0) return 32'h0;
        return m_stk[$];
    endfunction

    function automatic void model_reset();
        m_stk.delete();
        for (int i = 0; i < 16; i++) m_loc[i] = 32'h0;
        m_idx = 8'h0;
        m_pc  = 16'h0;
    endfunction

    function automatic void model_exec(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        logic [31:0] a, b;
        logic [3:0]  li;
        logic [15:0] nxt;
        li  = 4'(a1 % 8'd16);
        nxt = m_pc + 16'd1;
        if (op >= 8'h02 && op <= 8'h08) m_push(32'(int'(op) - 3));
        else case (op)
            8'h10: begin m_push({{24{a1[7]}}, a1}); nxt = m_pc + 16'd2; end
            8'h11: begin m_push({{16{a1[7]}}, a1, a2}); nxt = m_pc + 16'd3; end
            8'h15: begin m_push(m_loc[li]); m_idx = 8'(li); nxt = m_pc + 16'd2; end
            8'h1A, 8'h1B, 8'h1C, 8'h1D: begin
                m_push(m_loc[4'(op - 8'h1A)]); m_idx = op - 8'h1A;
            end
            8'h36: begin m_loc[li] = m_pop(); m_idx = 8'(li); nxt = m_pc + 16'd2; end
            8'h3B, 8'h3C, 8'h3D, 8'h3E: begin
                m_loc[4'(op - 8'h3B)] = m_pop(); m_idx = op - 8'h3B;
            end
            8'h57: void'(m_pop());
            8'h59: m_push(m_top());
            8'h60: begin b = m_pop(); a = m_pop(); m_push(a + b); end
            8'h64: begin b = m_pop(); a = m_pop(); m_push(a - b); end
            8'h84: begin
                m_loc[li] = m_loc[li] + {{24{a2[7]}}, a2};
                m_idx = 8'(li); nxt = m_pc + 16'd3;
            end
            8'h99: nxt = (m_pop() == 32'h0) ? m_pc + {a1, a2} : m_pc + 16'd3;
            8'h9A: nxt = (m_pop() != 32'h0) ? m_pc + {a1, a2} : m_pc + 16'd3;
            8'hA7: nxt = m_pc + {a1, a2};
            default: ;
        endcase
        m_pc = nxt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_pc"},  32'(program_counter), 32'(m_pc));
        check({tag, "_tos"}, dataparams, m_top());
        check({tag, "_idx"}, 32'(dataindex), 32'(m_idx));
    endtask

    // Inputs change 1 ns after an edge (or at a negedge) and commit on the next posedge.
    task automatic drive(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        op_code = op; arg1 = a1; arg2 = a2;
        model_exec(op, a1, a2);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_step(input string tag);
        logic [7:0] p;
        p = program_counter[7:0];
        drive(mem[p], mem[p + 8'd1], mem[p + 8'd2]);
        compare_model(tag);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        op_code = 8'h00; arg1 = 8'h00; arg2 = 8'h00;
        #1;
        model_reset();
        compare_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input int base, input int n, input logic [95:0] bytes);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int k = 0; k < n; k++) mem[base + k] = bytes[8*(n-1-k) +: 8];
    endtask

    initial begin
        tbl[0]  = '{8'h10, 8'hFF, 8'h00, 16'h0002, 32'hFFFFFFFF, 8'h00};
        tbl[1]  = '{8'h11, 8'h80, 8'h00, 16'h0005, 32'hFFFF8000, 8'h00};
        tbl[2]  = '{8'h60, 8'h00, 8'h00, 16'h0006, 32'hFFFF7FFF, 8'h00};
        tbl[3]  = '{8'h36, 8'h05, 8'h00, 16'h0008, 32'h00000000, 8'h05};
        tbl[4]  = '{8'h15, 8'h05, 8'h00, 16'h000A, 32'hFFFF7FFF, 8'h05};
        tbl[5]  = '{8'h84, 8'h05, 8'h01, 16'h000D, 32'hFFFF7FFF, 8'h05};
        tbl[6]  = '{8'h15, 8'h05, 8'h00, 16'h000F, 32'hFFFF8000, 8'h05};
        tbl[7]  = '{8'h64, 8'h00, 8'h00, 16'h0010, 32'hFFFFFFFF, 8'h05};
        tbl[8]  = '{8'h59, 8'h00, 8'h00, 16'h0011, 32'hFFFFFFFF, 8'h05};
        tbl[9]  = '{8'h9A, 8'h00, 8'h05, 16'h0016, 32'hFFFFFFFF, 8'h05};
        tbl[10] = '{8'h99, 8'h00, 8'h04, 16'h0019, 32'h00000000, 8'h05};
        tbl[11] = '{8'h99, 8'hFF, 8'hF0, 16'h0009, 32'h00000000, 8'h05};
        tbl[12] = '{8'hFF, 8'h00, 8'h00, 16'h000A, 32'h00000000, 8'h05};
        tbl[13] = '{8'h57, 8'h00, 8'h00, 16'h000B, 32'h00000000, 8'h05};
        tbl[14] = '{8'h60, 8'h00, 8'h00, 16'h000C, 32'h00000000, 8'h05};
        tbl[15] = '{8'h08, 8'h00, 8'h00, 16'h000D, 32'h00000005, 8'h05};
        tbl[16] = '{8'h64, 8'h00, 8'h00, 16'h000E, 32'hFFFFFFFB, 8'h05};
        tbl[17] = '{8'h3E, 8'h00, 8'h00, 16'h000F, 32'h00000000, 8'h03};
        tbl[18] = '{8'h1D, 8'h00, 8'h00, 16'h0010, 32'hFFFFFFFB, 8'h03};
        tbl[19] = '{8'hA7, 8'hFF, 8'hFD, 16'h000D, 32'hFFFFFFFB, 8'h03};
        tbl[20] = '{8'h02, 8'h00, 8'h00, 16'h000E, 32'hFFFFFFFF, 8'h03};
        tbl[21] = '{8'h64, 8'h00, 8'h00, 16'h000F, 32'hFFFFFFFC, 8'h03};
        tbl[22] = '{8'h84, 8'h13, 8'hFE, 16'h0012, 32'hFFFFFFFC, 8'h03};
        tbl[23] = '{8'h15, 8'h23, 8'h00, 16'h0014, 32'hFFFFFFF9, 8'h03};
        tbl[24] = '{8'h60, 8'h00, 8'h00, 16'h0015, 32'hFFFFFFF5, 8'h03};

        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].op, tbl[i].a1, tbl[i].a2);
            check($sformatf("vec%0d_pc", i),  32'(program_counter), 32'(tbl[i].pc));
            check($sformatf("vec%0d_tos", i), dataparams,           tbl[i].tos);
            check($sformatf("vec%0d_idx", i), 32'(dataindex),       32'(tbl[i].idx));
        end

        // nop held after reset: pc steps by one, stack stays empty
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(8'h00, 8'h00, 8'h00);
            check($sformatf("nop_pc%0d", i), 32'(program_counter), i);
            check($sformatf("nop_tos%0d", i), dataparams, 32'h0);
        end

        // iconst_2, istore_0, iconst_1, istore_1, iload_0, iload_1, iadd, istore_2, iload_2
        load_prog(0, 9, 96'h053B043C1A1B603D1C);
        do_reset();
        for (int i = 0; i < 9; i++) fetch_step("locals");
        check("locals_tos", dataparams, 32'd3);
        check("locals_idx", 32'(dataindex), 32'd2);
        check("locals_pc",  32'(program_counter), 32'd9);

        load_prog(16, 4, 96'h04990005);
        do_reset();
        for (int i = 0; i < 18; i++) fetch_step("ifeq_nt");
        check("ifeq_not_taken_pc", 32'(program_counter), 32'h14);

        load_prog(16, 4, 96'h049A0005);
        do_reset();
        for (int i = 0; i < 18; i++) fetch_step("ifne_t");
        check("ifne_taken_pc", 32'(program_counter), 32'h16);

        load_prog(32, 3, 96'hA7FFFD);
        do_reset();
        for (int i = 0; i < 33; i++) fetch_step("goto");
        check("goto_back_pc", 32'(program_counter), 32'h1D);

        // iinc on a live local leaves the stack alone
        do_reset();
        drive(8'h10, 8'h07, 8'h00);
        drive(8'h3C, 8'h00, 8'h00);
        drive(8'h84, 8'h01, 8'hFE);
        compare_model("iinc");
        check("iinc_idx", 32'(dataindex), 32'd1);
        check("iinc_tos", dataparams, 32'h0);
        drive(8'h1B, 8'h00, 8'h00);
        check("iinc_l1", dataparams, 32'd5);

        // overflow / dup-when-full / underflow
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(8'h10, 8'(i), 8'h00);
            compare_model("push");
        end
        check("ovf_tos", dataparams, 32'd16);
        drive(8'h59, 8'h00, 8'h00);
        compare_model("dup_full");
        check("dup_full_tos", dataparams, 32'd16);
        for (int i = 0; i < 17; i++) begin
            drive(8'h57, 8'h00, 8'h00);
            compare_model("pop");
        end
        check("underflow_tos", dataparams, 32'h0);
        drive(8'h08, 8'h00, 8'h00);
        check("after_underflow_tos", dataparams, 32'd5);

        // asynchronous reset between edges
        drive(8'h3C, 8'h00, 8'h00);
        drive(8'h10, 8'h2A, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",  32'(program_counter), 32'h0);
        check("async_rst_tos", dataparams, 32'h0);
        check("async_rst_idx", 32'(dataindex), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h1B, 8'h00, 8'h00);
        compare_model("post_rst_l1");

        // random instruction stream against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] op;
            if ($urandom_range(0, 4) == 0) op = 8'($urandom);
            else                           op = valid_ops[$urandom_range(0, 18)];
            drive(op, 8'($urandom), 8'($urandom));
            compare_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
